line_buffer_array: RTL and testbench
====================================

Name: line_buffer_array

Overview:
- Parametrised multi-line pixel buffer feeding the convolution window stage of the streaming NN datapath.
- Accepts one DATA_W sample per enabled cycle in raster order.
- Presents NUM_LINES+1 vertically aligned samples per column: the current sample plus the same column from the previous NUM_LINES lines.
- Adds frame restart, priming status, column position and masking of unfilled rows, none of which the single-line buffer has.

Parameters:
- DATA_W, 8, sample width in bits.
- LINE_LEN, 1280, samples per image line (delay depth of each line stage); legal range 2..4096.
- NUM_LINES, 2, number of line-delay stages; tap count is NUM_LINES+1; legal range 1..8.
- COL_W, 11, width of col_idx; must satisfy 2^COL_W >= LINE_LEN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_en  in  1  sample valid; data_in accepted on any rising edge with data_en=1.
- data_in  in  DATA_W  input sample.
- frame_start  in  1  synchronous frame restart; qualified only when data_en=1.
- tap_out  out  (NUM_LINES+1)*DATA_W  window column; slice k (bits k*DATA_W +: DATA_W) = sample delayed by k lines.
- tap_valid  out  1  tap_out carries a complete column (all rows filled).
- col_idx  out  COL_W  column index of the sample currently on tap_out.
- primed  out  1  level; 1 once NUM_LINES complete lines of the current frame are stored.

Behaviour:
- Reset (rst=0, async):
  - tap_out=0, tap_valid=0, col_idx=0, primed=0.
  - Write pointer=0, fill counter=0.
  - RAM contents are not cleared; masking below makes outputs deterministic.
- Storage: NUM_LINES circular RAMs of LINE_LEN x DATA_W sharing one pointer wr_ptr, 0..LINE_LEN-1.
  - Each accepted sample does a read-before-write at wr_ptr in every stage.
  - Stage 0 writes data_in; stage k writes the value just read from stage k-1.
- Latency: exactly 1 cycle. On the edge accepting sample S at column c, the registered outputs become:
  - slice 0 = S;
  - slice k = sample accepted k*LINE_LEN accepted samples earlier, same column c;
  - col_idx = c.
- Pointer: increments on each accept; wraps LINE_LEN-1 -> 0.
- Fill counter lines_filled (0..NUM_LINES, saturating): increments when an accept occurs at wr_ptr=LINE_LEN-1 and it is below NUM_LINES.
- Masking: slice k is forced to 0 when k > lines_filled, with lines_filled sampled before the accept.
- tap_valid: 1 in the cycle after an accept with lines_filled==NUM_LINES (pre-accept value); otherwise 0.
- primed = (lines_filled==NUM_LINES), registered.
- data_en=0: pointer, counters, RAMs, tap_out and col_idx hold; tap_valid drops to 0 next cycle. Gaps of any length are legal and invisible in data ordering.
- frame_start=1 with data_en=1:
  - the sample is treated as column 0 of the first line of a new frame;
  - wr_ptr and lines_filled are zeroed before the accept, so slices 1..NUM_LINES output 0, tap_valid=0, primed=0 next cycle;
  - write proceeds at address 0, and the pointer becomes 1 afterwards.
- frame_start with data_en=0 is ignored.
- Reset mid-line: immediate return to reset state; the next accepted sample is column 0 of row 0.
- No backpressure; the block accepts every enabled cycle.

Test Plan:
- LINE_LEN=8, NUM_LINES=2: after reset drive data_in=0..31 continuously (data_en=1, frame_start=1 on first sample):
  - samples 0..15 give tap_valid=0;
  - primed rises the cycle after sample 15;
  - sample 16 gives tap_out slices {0,8,16} and tap_valid=1;
  - sample 31 gives {15,23,31} with col_idx=7.
- Same config, data_en toggling 1/0 every cycle over 32 samples: identical tap_out sequence to the continuous run; tap_valid high only in cycles following an accept.
- Partial fill, LINE_LEN=8: after 10 samples (values 1..10) the last output is slice0=10, slice1=2, slice2=0 (masked), tap_valid=0, primed=0.
- Frame restart after 20 samples, with frame_start on sample value 0xAA: output is slice0=0xAA, slices 1,2 = 0, col_idx=0, primed=0; the next 15 samples keep tap_valid=0.
- Reset asserted mid-line (after sample 12), then released: all outputs 0 immediately; the next sample appears with col_idx=0 and masked upper slices.
- Default LINE_LEN=1280, 1600 random samples: slice1 equals data_in from 1280 accepts earlier; tap_valid never asserts, since 2 lines are not complete; primed stays 0; col_idx wraps 1279 -> 0.

Source files
------------

// File: rtl/line_buffer_array.sv
// rtl/line_buffer_array.sv - multi-line raster buffer presenting vertically aligned sample columns
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   data_en      sample accept strobe; every enabled cycle is accepted
//   data_in      DATA_W input sample, raster order
//   frame_start  restart at column 0 / row 0 of a new frame (only with data_en)
//   tap_out      NUM_LINES+1 slices; slice k is the same column k lines earlier
//   tap_valid    tap_out holds a full column (all rows filled), one cycle per accept
//   col_idx      column of the sample currently in slice 0
//   primed       NUM_LINES complete lines of the current frame are stored
module line_buffer_array #(
  parameter int DATA_W    = 8,
  parameter int LINE_LEN  = 1280,
  parameter int NUM_LINES = 2,
  parameter int COL_W     = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            data_en,
  input  logic [DATA_W-1:0]               data_in,
  input  logic                            frame_start,
  output logic [(NUM_LINES+1)*DATA_W-1:0] tap_out,
  output logic                            tap_valid,
  output logic [COL_W-1:0]                col_idx,
  output logic                            primed
);

  localparam int               AW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int               LF_W     = $clog2(NUM_LINES + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);
  localparam logic [LF_W-1:0]  FULL     = LF_W'(NUM_LINES);

  // Stage k holds the line that is k+1 lines older than the incoming one.
  logic [DATA_W-1:0] mem [NUM_LINES][LINE_LEN];

  logic [COL_W-1:0]                wr_ptr;
  logic [COL_W-1:0]                addr;
  logic [COL_W-1:0]                ptr_next;
  logic [LF_W-1:0]                 lines_filled;
  logic [LF_W-1:0]                 lf_eff;
  logic [LF_W-1:0]                 lf_next;
  logic [DATA_W-1:0]               rd [NUM_LINES];
  logic [(NUM_LINES+1)*DATA_W-1:0] col_next;

  // A frame restart behaves as if pointer and fill count were already zero
  // for this accept, so the restart sample lands at address 0 unmasked-free.
  always_comb begin
    addr     = frame_start ? '0 : wr_ptr;
    lf_eff   = frame_start ? '0 : lines_filled;
    ptr_next = (addr == LAST_COL) ? '0 : addr + COL_W'(1);
    lf_next  = lf_eff;
    if (addr == LAST_COL && lf_eff < FULL) begin
      lf_next = lf_eff + LF_W'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LINES; k++) begin
      rd[k] = mem[k][addr[AW-1:0]];
    end
  end

  // Rows not yet written in this frame read stale RAM; force them to zero.
  always_comb begin
    col_next              = '0;
    col_next[0 +: DATA_W] = data_in;
    for (int k = 1; k <= NUM_LINES; k++) begin
      col_next[k*DATA_W +: DATA_W] = (k > int'(lf_eff)) ? '0 : rd[k-1];
    end
  end

  // Read-before-write: each stage shifts its old value into the next stage.
  always_ff @(posedge clk) begin
    if (data_en) begin
      mem[0][addr[AW-1:0]] <= data_in;
      for (int k = 1; k < NUM_LINES; k++) begin
        mem[k][addr[AW-1:0]] <= rd[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      lines_filled <= '0;
      tap_out      <= '0;
      tap_valid    <= 1'b0;
      col_idx      <= '0;
      primed       <= 1'b0;
    end else if (data_en) begin
      wr_ptr       <= ptr_next;
      lines_filled <= lf_next;
      tap_out      <= col_next;
      tap_valid    <= (lf_eff == FULL);
      col_idx      <= addr;
      primed       <= (lf_next == FULL);
    end else begin
      tap_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_array.sv
// tb/tb_line_buffer_array.sv - directed self-checking bench for line_buffer_array
module tb_line_buffer_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_en = 1'b0, a_fs = 1'b0;
  logic [7:0]  a_d = 8'h00;
  logic [23:0] a_tap;
  logic        a_tv, a_pr;
  logic [10:0] a_col;

  logic        b_en = 1'b0, b_fs = 1'b0;
  logic [7:0]  b_d = 8'h00;
  logic [23:0] b_tap;
  logic        b_tv, b_pr;
  logic [10:0] b_col;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  hist [1600];

  always #5 clk = ~clk;

  line_buffer_array #(.DATA_W(8), .LINE_LEN(8), .NUM_LINES(2), .COL_W(11)) dut_a (
    .clk(clk), .rst(rst), .data_en(a_en), .data_in(a_d), .frame_start(a_fs),
    .tap_out(a_tap), .tap_valid(a_tv), .col_idx(a_col), .primed(a_pr)
  );

  line_buffer_array dut_b (
    .clk(clk), .rst(rst), .data_en(b_en), .data_in(b_d), .frame_start(b_fs),
    .tap_out(b_tap), .tap_valid(b_tv), .col_idx(b_col), .primed(b_pr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic en, input logic fs, input logic [7:0] d);
    @(negedge clk);
    a_en = en; a_fs = fs; a_d = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic en, input logic fs, input logic [7:0] d);
    @(negedge clk);
    b_en = en; b_fs = fs; b_d = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] exp_tap8(input int i);
    logic [7:0] s1, s2;
    s1 = (i >= 8)  ? 8'(i - 8)  : 8'h00;
    s2 = (i >= 16) ? 8'(i - 16) : 8'h00;
    return {s2, s1, 8'(i)};
  endfunction

  initial begin
    logic [23:0] held_tap;
    logic [7:0]  s1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tap", 32'(a_tap), 32'h0);
    chk("reset_tv",  32'(a_tv),  32'h0);
    chk("reset_col", 32'(a_col), 32'h0);
    chk("reset_pr",  32'(a_pr),  32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Continuous run 0..31
    for (int i = 0; i < 32; i++) begin
      step_a(1'b1, i == 0, 8'(i));
      chk($sformatf("cont_tap[%0d]", i), 32'(a_tap), 32'(exp_tap8(i)));
      chk($sformatf("cont_tv[%0d]", i),  32'(a_tv),  32'(i >= 16));
      chk($sformatf("cont_col[%0d]", i), 32'(a_col), 32'(i % 8));
      chk($sformatf("cont_pr[%0d]", i),  32'(a_pr),  32'(i >= 15));
    end

    // Toggling data_en: same data sequence, tap_valid only after accepts
    for (int i = 0; i < 32; i++) begin
      step_a(1'b1, i == 0, 8'(i));
      chk($sformatf("tog_tap[%0d]", i), 32'(a_tap), 32'(exp_tap8(i)));
      chk($sformatf("tog_tv[%0d]", i),  32'(a_tv),  32'(i >= 16));
      chk($sformatf("tog_col[%0d]", i), 32'(a_col), 32'(i % 8));
      step_a(1'b0, 1'b0, 8'hEE);
      chk($sformatf("tog_idle_tv[%0d]", i),  32'(a_tv),  32'h0);
      chk($sformatf("tog_idle_tap[%0d]", i), 32'(a_tap), 32'(exp_tap8(i)));
      chk($sformatf("tog_idle_col[%0d]", i), 32'(a_col), 32'(i % 8));
      chk($sformatf("tog_idle_pr[%0d]", i),  32'(a_pr),  32'(i >= 15));
    end

    // Partial fill: values 1..10, third row still masked
    for (int i = 1; i <= 10; i++) step_a(1'b1, i == 1, 8'(i));
    chk("part_tap", 32'(a_tap), 32'h00020A);
    chk("part_tv",  32'(a_tv),  32'h0);
    chk("part_pr",  32'(a_pr),  32'h0);
    chk("part_col", 32'(a_col), 32'h1);

    // Frame restart after 20 samples of a full frame
    for (int i = 0; i < 20; i++) step_a(1'b1, i == 0, 8'(i));
    chk("pre_restart_pr", 32'(a_pr), 32'h1);
    step_a(1'b1, 1'b1, 8'hAA);
    chk("restart_tap", 32'(a_tap), 32'h0000AA);
    chk("restart_col", 32'(a_col), 32'h0);
    chk("restart_pr",  32'(a_pr),  32'h0);
    chk("restart_tv",  32'(a_tv),  32'h0);
    for (int j = 0; j < 15; j++) begin
      step_a(1'b1, 1'b0, 8'(8'h10 + j));
      chk($sformatf("restart_tv[%0d]", j), 32'(a_tv), 32'h0);
    end

    // Reset mid-line after 12 samples
    for (int i = 0; i < 12; i++) step_a(1'b1, i == 0, 8'(8'h40 + i));
    @(negedge clk);
    a_en = 1'b0;
    rst  = 1'b0;
    #1;
    chk("midrst_tap", 32'(a_tap), 32'h0);
    chk("midrst_col", 32'(a_col), 32'h0);
    chk("midrst_tv",  32'(a_tv),  32'h0);
    chk("midrst_pr",  32'(a_pr),  32'h0);
    @(negedge clk);
    rst = 1'b1;
    step_a(1'b1, 1'b0, 8'h77);
    chk("postrst_tap", 32'(a_tap), 32'h000077);
    chk("postrst_col", 32'(a_col), 32'h0);
    chk("postrst_tv",  32'(a_tv),  32'h0);
    step_a(1'b0, 1'b0, 8'h00);

    // Default geometry: 1600 random samples, one line of history only
    for (int i = 0; i < 1600; i++) begin
      hist[i] = 8'($urandom_range(0, 255));
      step_b(1'b1, i == 0, hist[i]);
      s1 = (i >= 1280) ? hist[i-1280] : 8'h00;
      chk($sformatf("def_tap[%0d]", i), 32'(b_tap), 32'({8'h00, s1, hist[i]}));
      chk($sformatf("def_tv[%0d]", i),  32'(b_tv),  32'h0);
      chk($sformatf("def_pr[%0d]", i),  32'(b_pr),  32'h0);
      chk($sformatf("def_col[%0d]", i), 32'(b_col), 32'(i % 1280));
    end
    step_b(1'b0, 1'b0, 8'h00);
    held_tap = {8'h00, hist[1599-1280], hist[1599]};
    chk("def_idle_tap", 32'(b_tap), 32'(held_tap));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
